// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op-codes and default sizes for the return and data stacks
package stack_pkg;

    localparam int STACK_WIDTH = 16;
    localparam int STACK_DEPTH = 64;

    localparam logic [1:0] STACK_NOP     = 2'd0;
    localparam logic [1:0] STACK_PUSH    = 2'd1;
    localparam logic [1:0] STACK_REPLACE = 2'd2;
    localparam logic [1:0] STACK_POP     = 2'd3;

endpackage

// File: rtl/stack_cell.sv
// rtl/stack_cell.sv - one stack entry: register with async clear and hold/above/below/w mux
module stack_cell
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] below,
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d;

    always_comb begin
        d = q;
        case (op)
            STACK_PUSH:    d = above;
            STACK_REPLACE: d = w;
            STACK_POP:     d = below;
            default:       d = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/return_stack.sv
// rtl/return_stack.sv - shift-register LIFO return stack, top two entries exposed as a and b
module return_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [1:0]              stackOP,
    input  logic [WIDTH-1:0]        w,
    output logic signed [WIDTH-1:0] a,
    output logic signed [WIDTH-1:0] b
);

    logic [WIDTH-1:0] entry [DEPTH];

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_cell
            logic [WIDTH-1:0] above;
            logic [WIDTH-1:0] below;
            logic [1:0]       op;

            if (i == 0) begin : g_top
                assign above = w;
                assign op    = stackOP;
            end else begin : g_inner
                assign above = entry[i-1];
                // REPLACE only touches the top entry; every other cell holds
                assign op    = (stackOP == STACK_REPLACE) ? STACK_NOP : stackOP;
            end

            if (i == DEPTH-1) begin : g_bottom
                assign below = '0;
            end else begin : g_upper
                assign below = entry[i+1];
            end

            stack_cell #(.WIDTH(WIDTH)) u_cell (
                .clk   (CLK),
                .rst_n (reset),
                .op    (op),
                .above (above),
                .below (below),
                .w     (w),
                .q     (entry[i])
            );
        end
    endgenerate

    assign a = entry[0];
    assign b = entry[1];

endmodule

// File: tb/tb_return_stack.sv
// tb/tb_return_stack.sv - directed self-checking bench for return_stack
module tb_return_stack;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_REPLACE = 2'd2;
    localparam logic [1:0] OP_POP     = 2'd3;

    logic               CLK;
    logic               reset;
    logic [1:0]         stackOP;
    logic [15:0]        w;
    logic signed [15:0] a;
    logic signed [15:0] b;

    int n_checks;
    int n_fail;

    return_stack #(.WIDTH(16), .DEPTH(64)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .stackOP (stackOP),
        .w       (w),
        .a       (a),
        .b       (b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%04h), expected %0d (0x%04h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] wv);
        stackOP = op;
        w       = wv;
        @(posedge CLK);
        @(negedge CLK);
        stackOP = OP_NOP;
        w       = 16'h0000;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        stackOP  = OP_NOP;
        w        = 16'h0000;

        @(negedge CLK);
        check("reset_a", a, 16'd0);
        check("reset_b", b, 16'd0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) do_op(OP_NOP, 16'hFFFF);
        check("nop_a", a, 16'd0);
        check("nop_b", b, 16'd0);

        do_op(OP_PUSH, 16'd1);
        check("push1_a", a, 16'd1);
        check("push1_b", b, 16'd0);

        apply_reset();
        do_op(OP_PUSH, 16'd2);
        do_op(OP_PUSH, 16'd4);
        check("push24_a", a, 16'd4);
        check("push24_b", b, 16'd2);
        do_op(OP_NOP, 16'h1234);
        check("nop_hold_a", a, 16'd4);
        do_op(OP_POP, 16'h5555);
        check("pop1_a", a, 16'd2);
        check("pop1_b", b, 16'd0);
        do_op(OP_POP, 16'd0);
        check("pop2_a", a, 16'd0);
        do_op(OP_POP, 16'd0);
        check("underflow_a", a, 16'd0);
        check("underflow_b", b, 16'd0);

        apply_reset();
        for (int k = 1; k <= 64; k++) do_op(OP_PUSH, 16'(k));
        check("full_a", a, 16'd64);
        check("full_b", b, 16'd63);
        for (int k = 0; k < 63; k++) do_op(OP_POP, 16'd0);
        check("drain63_a", a, 16'd1);
        check("drain63_b", b, 16'd0);
        do_op(OP_POP, 16'd0);
        check("drain64_a", a, 16'd0);

        apply_reset();
        for (int k = 1; k <= 65; k++) do_op(OP_PUSH, 16'(k));
        check("ovf_a", a, 16'd65);
        check("ovf_b", b, 16'd64);
        for (int k = 0; k < 63; k++) do_op(OP_POP, 16'd0);
        check("ovf_pop63_a", a, 16'd2);
        check("ovf_pop63_b", b, 16'd0);
        do_op(OP_POP, 16'd0);
        check("ovf_pop64_a", a, 16'd0);

        apply_reset();
        do_op(OP_PUSH, 16'd5);
        do_op(OP_PUSH, 16'd7);
        do_op(OP_REPLACE, 16'hFFFD);
        check("replace_a", a, 16'hFFFD);
        check("replace_b", b, 16'd5);
        check("replace_neg", {15'd0, (a < 0)}, 16'd1);
        do_op(OP_POP, 16'd0);
        check("replace_pop_a", a, 16'd5);

        apply_reset();
        do_op(OP_PUSH, 16'd5);
        do_op(OP_PUSH, 16'd7);
        check("pre_async_a", a, 16'd7);
        #2;
        reset = 1'b0;
        #1;
        check("async_a", a, 16'd0);
        check("async_b", b, 16'd0);
        @(negedge CLK);
        stackOP = OP_PUSH;
        w       = 16'd9;
        @(posedge CLK);
        @(negedge CLK);
        check("reset_overrides_op", a, 16'd0);
        stackOP = OP_NOP;
        reset   = 1'b1;
        do_op(OP_PUSH, 16'd9);
        check("post_reset_push", a, 16'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/return_stack.md
# return_stack

Fixed-depth LIFO return stack for the stack processor, holding subroutine return addresses and loop data. It is implemented as a shift register: the top two entries are exposed combinationally as `a` and `b`, and one stack operation executes per clock. On overflow the oldest (bottom) entry is silently discarded. Underflow yields zeros.

## Interface
- `WIDTH`, 16, data width of every entry.
- `DEPTH`, 64, number of entries.

- `CLK`  input  1  system clock; all state changes occur on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; clears every entry to 0.
- `stackOP`  input  2  operation select, sampled on the rising edge of `CLK`.
- `w`  input  WIDTH  write data for push and replace.
- `a`  output  WIDTH (signed)  top of stack (entry 0).
- `b`  output  WIDTH (signed)  second entry (entry 1).

## Operation
- Storage: entries 0..DEPTH-1. Entry 0 is the top.
- There is no pointer and no full/empty flag. Depth is implicit because unused entries hold 0.
- `stackOP` encoding:
  - 0 = NOP: all entries hold.
  - 1 = PUSH: entry[i] <= entry[i-1] for i = DEPTH-1..1, then entry[0] <= `w`.
  - 2 = REPLACE: entry[0] <= `w`; all other entries hold.
  - 3 = POP: entry[i] <= entry[i+1] for i = 0..DEPTH-2, then entry[DEPTH-1] <= 0.
- Overflow: a PUSH with DEPTH valid entries discards entry[DEPTH-1] with no error indication. After 65 pushes of 1..65, the value 1 is lost.
- Underflow: a POP on an empty or partly-empty stack shifts in zeros. `a` reads 0 once all pushed values are popped. Further POPs keep all entries at 0.
- Data is stored unmodified. `a` and `b` are the stored bits, interpreted as two's-complement signed.
- `a` and `b` are continuous assignments from entry[0] and entry[1]. They carry no extra register stage.

## Timing
- Reset:
  - While `reset` = 0, all entries are 0, so `a` = `b` = 0.
  - Reset takes effect immediately, without waiting for a clock edge.
  - Reset asserted mid-operation overrides any `stackOP` on the same edge.
  - On deassertion, the first operation executes at the next rising edge.
- Latency: one cycle. The result of an operation sampled at edge N is visible on `a`/`b` right after edge N. It is stable for the next sample point.
- One operation per cycle, with no handshake. Back-to-back PUSH/POP on consecutive cycles is fully supported.
- `w` is only sampled for PUSH/REPLACE and is ignored otherwise.

## Structure
- Shared package (e.g. `stack_pkg`):
  - op-code constants `STACK_NOP` = 2'd0, `STACK_PUSH` = 2'd1, `STACK_REPLACE` = 2'd2, `STACK_POP` = 2'd3.
  - default `WIDTH` / `DEPTH` constants.
  - the data stack uses the same package.
- One natural sub-module: `stack_cell`. It is a single WIDTH-bit register with async active-low clear and a 4-way next-value mux (hold / from-above / from-below / `w`).
  - `return_stack` instantiates DEPTH cells in a generate loop.
  - Cell 0's from-above input is `w`. The bottom cell's from-below input is 0.

## Test plan
- Hold `reset` low for one cycle, then release -> `a` = 0, `b` = 0. Then NOP for several cycles -> `a` and `b` remain 0.
- After reset, PUSH 1 -> `a` = 1, `b` = 0.
- After reset, PUSH 2, PUSH 4 -> `a` = 4, `b` = 2. Then POP -> `a` = 2. Then POP -> `a` = 0. Then POP again -> `a` = 0 (underflow).
- After reset, PUSH 1..64 -> `a` = 64. Then 63 POPs -> `a` = 1, `b` = 0.
- After reset, PUSH 1..65, then 64 POPs -> `a` = 0 (value 1 discarded on overflow). Before the POPs, `a` = 65 and `b` = 64.
- After reset, PUSH 5, PUSH 7, then REPLACE with `w` = -3 -> `a` = -3, `b` = 5.
- After reset, PUSH 5, PUSH 7, then assert `reset` between clock edges -> `a` and `b` go to 0 immediately (async clear).
